// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter and timer blocks:
// counter type codes and default widths.
package counter_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_ACC_W  = 8;

    typedef enum logic [1:0] {
        CT_OFF  = 2'b00,
        CT_UP   = 2'b01,
        CT_DOWN = 2'b10,
        CT_OFF3 = 2'b11
    } cnt_type_e;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among pending requests,
// search starts just above the last granted channel.
module rr_arbiter
    import counter_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CH_W-1:0] r_last;
    logic [CH_W-1:0] w_idx;
    logic [CH_W-1:0] w_gidx;

    // Walk from farthest to nearest so the nearest pending channel wins.
    always_comb begin
        grant = '0;
        w_idx = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = CH_W'((int'(r_last) + k) % NUM_CH);
            if (req[w_idx]) begin
                grant        = '0;
                grant[w_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        w_gidx = r_last;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) w_gidx = CH_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= CH_W'(NUM_CH - 1);
        end else if (advance && (|grant)) begin
            r_last <= w_gidx;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// Multi-channel up/down counter sharing one inc/dec datapath,
// with round-robin scheduling of pending count events.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ACC_W  = DEF_ACC_W,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [1:0]        cfg_type,
    input  logic [ACC_W-1:0]  cfg_preset,
    input  logic [NUM_CH-1:0] cnt_req,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [ACC_W-1:0]  rd_acc,
    output logic [NUM_CH-1:0] DN,
    output logic [NUM_CH-1:0] CU,
    output logic [NUM_CH-1:0] CD,
    output logic [NUM_CH-1:0] ovr,
    output logic              busy
);

    cnt_type_e         r_type   [NUM_CH];
    logic [ACC_W-1:0]  r_preset [NUM_CH];
    logic [ACC_W-1:0]  r_acc    [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_dn;
    logic [NUM_CH-1:0] r_cu;
    logic [NUM_CH-1:0] r_cd;
    logic [NUM_CH-1:0] r_ovr;

    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_cfg_sel;
    logic [CH_W-1:0]   w_gidx;
    logic              w_gany;
    logic              w_up;
    logic              w_down;
    logic              w_hit;
    logic [ACC_W-1:0]  w_acc_cur;
    logic [ACC_W-1:0]  w_pre_cur;
    logic [ACC_W-1:0]  w_acc_nxt;

    assign w_gany = |w_grant;

    rr_arbiter #(
        .NUM_CH  (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (r_pend),
        .advance (w_gany),
        .grant   (w_grant)
    );

    always_comb begin
        w_gidx    = '0;
        w_cfg_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant[i]) w_gidx = CH_W'(i);
            w_cfg_sel[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    // Single saturating inc/dec unit, steered by the granted channel.
    always_comb begin
        w_acc_cur = r_acc[w_gidx];
        w_pre_cur = r_preset[w_gidx];
        w_up      = (r_type[w_gidx] == CT_UP);
        w_down    = (r_type[w_gidx] == CT_DOWN);
        w_acc_nxt = w_acc_cur;
        if (w_up && (w_acc_cur != '1)) begin
            w_acc_nxt = w_acc_cur + ACC_W'(1);
        end else if (w_down && (w_acc_cur != '0)) begin
            w_acc_nxt = w_acc_cur - ACC_W'(1);
        end
        w_hit = (w_up   && (w_acc_nxt >= w_pre_cur))
             || (w_down && (w_acc_nxt <= w_pre_cur));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_type[i]   <= CT_OFF;
                r_preset[i] <= '0;
                r_acc[i]    <= '0;
            end
            r_pend <= '0;
            r_dn   <= '0;
            r_cu   <= '0;
            r_cd   <= '0;
            r_ovr  <= '0;
        end else begin
            r_cu <= '0;
            r_cd <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_cfg_sel[i]) begin
                    r_type[i]   <= cnt_type_e'(cfg_type);
                    r_preset[i] <= cfg_preset;
                    r_acc[i]    <= (cfg_type == CT_UP) ? '0 : '1;
                    r_dn[i]     <= 1'b0;
                    r_pend[i]   <= 1'b0;
                    r_ovr[i]    <= 1'b0;
                end else begin
                    r_pend[i] <= (r_pend[i] && !w_grant[i]) || cnt_req[i];
                    if (cnt_req[i] && r_pend[i] && !w_grant[i]) begin
                        r_ovr[i] <= 1'b1;
                    end
                    // Disabled channels just drop the grant.
                    if (w_grant[i] && (w_up || w_down)) begin
                        r_acc[i] <= w_acc_nxt;
                        r_cu[i]  <= w_up;
                        r_cd[i]  <= w_down;
                        if (w_hit) r_dn[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign rd_acc = r_acc[rd_ch];
    assign DN     = r_dn;
    assign CU     = r_cu;
    assign CD     = r_cd;
    assign ovr    = r_ovr;
    assign busy   = |r_pend;

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: vector table plus a saturation run,
// expected results flow through a scoreboard queue.
module tb_counter_sched;

    logic       clk;
    logic       reset;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_type;
    logic [7:0] cfg_preset;
    logic [3:0] cnt_req;
    logic [1:0] rd_ch;
    logic [7:0] rd_acc;
    logic [3:0] DN;
    logic [3:0] CU;
    logic [3:0] CD;
    logic [3:0] ovr;
    logic       busy;

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] ch;
        logic [1:0] ty;
        logic [7:0] pre;
        logic [3:0] req;
        logic [1:0] rd;
        logic [7:0] acc;
        logic [3:0] dn;
        logic [3:0] cu;
        logic [3:0] cd;
        logic [3:0] ov;
        logic       busy;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    counter_sched #(
        .NUM_CH     (4),
        .ACC_W      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_type   (cfg_type),
        .cfg_preset (cfg_preset),
        .cnt_req    (cnt_req),
        .rd_ch      (rd_ch),
        .rd_acc     (rd_acc),
        .DN         (DN),
        .CU         (CU),
        .CD         (CD),
        .ovr        (ovr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(
        input int rst, input int we, input int ch, input int ty,
        input int pre, input int req, input int rd, input int acc,
        input int dn, input int cu, input int cd, input int ov,
        input int bsy
    );
        vec_t t;
        t.rst  = 1'(rst);
        t.we   = 1'(we);
        t.ch   = 2'(ch);
        t.ty   = 2'(ty);
        t.pre  = 8'(pre);
        t.req  = 4'(req);
        t.rd   = 2'(rd);
        t.acc  = 8'(acc);
        t.dn   = 4'(dn);
        t.cu   = 4'(cu);
        t.cd   = 4'(cd);
        t.ov   = 4'(ov);
        t.busy = 1'(bsy);
        return t;
    endfunction

    task automatic cmp(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        vec_t e;
        @(negedge clk);
        reset      = t.rst;
        cfg_we     = t.we;
        cfg_ch     = t.ch;
        cfg_type   = t.ty;
        cfg_preset = t.pre;
        cnt_req    = t.req;
        rd_ch      = t.rd;
        sbq.push_back(t);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s sb: got empty queue, expected entry", tag);
        end else begin
            e = sbq.pop_front();
            cmp({tag, " acc"},  rd_acc,      e.acc);
            cmp({tag, " DN"},   8'(DN),      8'(e.dn));
            cmp({tag, " CU"},   8'(CU),      8'(e.cu));
            cmp({tag, " CD"},   8'(CD),      8'(e.cd));
            cmp({tag, " ovr"},  8'(ovr),     8'(e.ov));
            cmp({tag, " busy"}, 8'(busy),    8'(e.busy));
        end
    endtask

    initial begin
        int a;
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_type   = '0;
        cfg_preset = '0;
        cnt_req    = '0;
        rd_ch      = '0;

        // rst we ch ty pre req rd | acc dn cu cd ovr busy
        tbl.push_back(v(1,1,0,1,5,  'b1111,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        // ch0 up, preset 3, four requests
        tbl.push_back(v(0,1,0,1,3,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b0001,0, 0,  'b0000,'b0000,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0001,0, 1,  'b0000,'b0001,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0001,0, 2,  'b0000,'b0001,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0001,0, 3,  'b0001,'b0001,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,0, 4,  'b0001,'b0001,'b0000,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b0000,0, 4,  'b0001,'b0000,'b0000,'b0000,0));
        // ch1 down, preset 250, five requests
        tbl.push_back(v(0,1,1,2,250,'b0000,1, 255,'b0001,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b0010,1, 255,'b0001,'b0000,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0010,1, 254,'b0001,'b0000,'b0010,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0010,1, 253,'b0001,'b0000,'b0010,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0010,1, 252,'b0001,'b0000,'b0010,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0010,1, 251,'b0001,'b0000,'b0010,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,1, 250,'b0011,'b0000,'b0010,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b0000,1, 250,'b0011,'b0000,'b0000,'b0000,0));
        // reset, all four up, then a burst on every channel
        tbl.push_back(v(1,0,0,0,0,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,1,0,1,2,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,1,1,1,2,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,1,2,1,2,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,1,3,1,2,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b1111,0, 0,  'b0000,'b0000,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,0, 1,  'b0000,'b0001,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,1, 1,  'b0000,'b0010,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,2, 1,  'b0000,'b0100,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,3, 1,  'b0000,'b1000,'b0000,'b0000,0));
        // ch2 requested twice while ch0/ch1 pending -> overrun
        tbl.push_back(v(0,0,0,0,0,  'b0111,2, 1,  'b0000,'b0000,'b0000,'b0000,1));
        tbl.push_back(v(0,0,0,0,0,  'b0100,2, 1,  'b0001,'b0001,'b0000,'b0100,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,2, 1,  'b0011,'b0010,'b0000,'b0100,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,2, 2,  'b0111,'b0100,'b0000,'b0100,0));
        tbl.push_back(v(0,0,0,0,0,  'b0000,2, 2,  'b0111,'b0000,'b0000,'b0100,0));
        // cfg on ch0 in its grant cycle, pointer must still move on
        tbl.push_back(v(0,0,0,0,0,  'b0001,0, 2,  'b0111,'b0000,'b0000,'b0100,1));
        tbl.push_back(v(0,1,0,1,5,  'b0000,0, 0,  'b0110,'b0000,'b0000,'b0100,0));
        tbl.push_back(v(0,0,0,0,0,  'b0011,0, 0,  'b0110,'b0000,'b0000,'b0100,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,1, 3,  'b0110,'b0010,'b0000,'b0100,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,0, 1,  'b0110,'b0001,'b0000,'b0100,0));
        // disabled channel swallows its grant
        tbl.push_back(v(0,1,3,0,0,  'b0000,3, 255,'b0110,'b0000,'b0000,'b0100,0));
        tbl.push_back(v(0,0,0,0,0,  'b1000,3, 255,'b0110,'b0000,'b0000,'b0100,1));
        tbl.push_back(v(0,0,0,0,0,  'b0000,3, 255,'b0110,'b0000,'b0000,'b0100,0));
        // cfg and request on the same channel: request dropped
        tbl.push_back(v(0,1,2,1,9,  'b0100,2, 0,  'b0010,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b0000,2, 0,  'b0010,'b0000,'b0000,'b0000,0));
        // reset with everything pending
        tbl.push_back(v(0,0,0,0,0,  'b1111,0, 1,  'b0010,'b0000,'b0000,'b0000,1));
        tbl.push_back(v(1,0,0,0,0,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));
        tbl.push_back(v(0,0,0,0,0,  'b0000,0, 0,  'b0000,'b0000,'b0000,'b0000,0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Up counter run into saturation at 255, preset 200.
        apply(v(0,1,0,1,200,'b0000,0, 0,'b0000,'b0000,'b0000,'b0000,0), "sat_cfg");
        for (int k = 0; k <= 258; k++) begin
            a = (k > 255) ? 255 : k;
            apply(v(0, 0, 0, 0, 0,
                    (k <= 256) ? 'b0001 : 'b0000, 0,
                    a,
                    (a >= 200) ? 'b0001 : 'b0000,
                    (k >= 1 && k <= 257) ? 'b0001 : 'b0000,
                    'b0000, 'b0000,
                    (k <= 256) ? 1 : 0),
                  $sformatf("sat%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
